// File: rtl/pipe_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiplier and restoring divider feeding HI/LO.
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiply (divide stays iterative).
module pipe_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mul_start_i,
  input  logic               div_start_i,
  input  logic               signed_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o,
  output logic               hi_wena_o,
  output logic               lo_wena_o,
  output logic [1:0]         hi_select_o,
  output logic [1:0]         lo_select_o,
  output logic               busy_o,
  output logic               stall_o,
  output logic               done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [1:0]         hi_sel_q, hi_sel_d;
  logic [1:0]         lo_sel_q, lo_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               last_s;
  logic               sign_diff_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_add_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   div_q_raw_s, div_r_raw_s;

  assign accept_s    = (state_q == S_IDLE) && !flush_i && (mul_start_i || div_start_i);
  assign last_s      = (cnt_q == CNT_LAST);
  assign sign_diff_s = signed_i && (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]);
  assign a_mag_s     = (signed_i && op_a_i[WIDTH-1]) ? (ZERO_W - op_a_i) : op_a_i;
  assign b_mag_s     = (signed_i && op_b_i[WIDTH-1]) ? (ZERO_W - op_b_i) : op_b_i;

  // Shift-add: upper half gathers the multiplicand when the multiplier LSB (acc[0]) is set.
  assign mul_add_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_add_s, acc_q[WIDTH-1:1]};

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
  assign div_next_s  = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign div_q_raw_s = div_next_s[WIDTH-1:0];
  assign div_r_raw_s = div_next_s[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FASTMUL_EN
  logic [2*WIDTH-1:0] fast_a_s, fast_b_s, fast_prod_s;
  assign fast_a_s    = {{WIDTH{signed_i & op_a_i[WIDTH-1]}}, op_a_i};
  assign fast_b_s    = {{WIDTH{signed_i & op_b_i[WIDTH-1]}}, op_b_i};
  assign fast_prod_s = fast_a_s * fast_b_s;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    raw_a_d     = raw_a_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    div_zero_d  = div_zero_q;
    product_d   = product_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    hi_sel_d    = 2'b00;
    lo_sel_d    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cnt_d = CNT_ZERO;
          if (mul_start_i) begin
`ifdef MULDIV_FASTMUL_EN
            state_d   = S_DONE;
            product_d = fast_prod_s;
            hi_sel_d  = 2'b10;
            lo_sel_d  = 2'b10;
`else
            state_d   = S_MUL;
            acc_d     = {ZERO_W, b_mag_s};
            opnd_d    = a_mag_s;
            neg_res_d = sign_diff_s;
`endif
          end else begin
            state_d    = S_DIV;
            acc_d      = {ZERO_W, a_mag_s};
            opnd_d     = b_mag_s;
            raw_a_d    = op_a_i;
            div_zero_d = (op_b_i == ZERO_W);
            neg_res_d  = sign_diff_s;
            neg_rem_d  = signed_i && op_a_i[WIDTH-1];
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (last_s) begin
            state_d   = S_DONE;
            product_d = neg_res_q ? (ZERO_2W - mul_next_s) : mul_next_s;
            hi_sel_d  = 2'b10;
            lo_sel_d  = 2'b10;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (last_s) begin
            state_d  = S_DONE;
            hi_sel_d = 2'b11;
            lo_sel_d = 2'b11;
            if (div_zero_q) begin
              quotient_d  = ONES_W;
              remainder_d = raw_a_q;
            end else begin
              quotient_d  = neg_res_q ? (ZERO_W - div_q_raw_s) : div_q_raw_s;
              remainder_d = neg_rem_q ? (ZERO_W - div_r_raw_s) : div_r_raw_s;
            end
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      acc_q       <= ZERO_2W;
      opnd_q      <= ZERO_W;
      raw_a_q     <= ZERO_W;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      product_q   <= ZERO_2W;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      hi_sel_q    <= 2'b00;
      lo_sel_q    <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      raw_a_q     <= raw_a_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      div_zero_q  <= div_zero_d;
      product_q   <= product_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      hi_sel_q    <= hi_sel_d;
      lo_sel_q    <= lo_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // A flush landing in the DONE cycle kills the write strobe in that same cycle.
  assign hi_wena_o   = done_q && !flush_i;
  assign lo_wena_o   = done_q && !flush_i;
  assign done_o      = done_q && !flush_i;
  assign stall_o     = accept_s || (state_q == S_MUL) || (state_q == S_DIV);
  assign busy_o      = busy_q;
  assign hi_select_o = hi_sel_q;
  assign lo_select_o = lo_sel_q;
  assign product_o   = product_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule
